// File: rtl/water_cycle_controller.sv
// Fill / wash / drain sequencer driving the inlet and drain valves and the flow monitor.
// Optional macro WFC_RETRY_EN: one RECOVER retry per run before a flow error escalates to FAULT.
module water_cycle_controller #(
  parameter int unsigned FULL_LEVEL  = 800,
  parameter int unsigned EMPTY_LEVEL = 20,
  parameter int unsigned WASH_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       clear_fault,
  input  logic [9:0] water_level_sensor,
  input  logic       error_flag,
  output logic       mode,
  output logic       mon_reset,
  output logic       inlet_valve,
  output logic       drain_valve,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FILL    = 3'd1;
  localparam logic [2:0] ST_WASH    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;
  localparam logic [2:0] ST_RECOVER = 3'd6;

  localparam logic [15:0] WASH_LAST = 16'(WASH_CYCLES - 32'd1);

  // Output vector order: mode, mon_reset, inlet_valve, drain_valve, done, fault
  function automatic logic [5:0] decode_outputs(input logic [2:0] st);
    logic [5:0] v;
    case (st)
      ST_FILL:  v = 6'b101000;
      ST_DRAIN: v = 6'b000100;
      ST_DONE:  v = 6'b010010;
      ST_FAULT: v = 6'b010001;
      default:  v = 6'b010000;
    endcase
    return v;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [15:0] r_wash_cnt;
  logic [15:0] w_next_wash_cnt;
  logic [5:0]  r_outputs;
  logic        w_full;
  logic        w_empty;
  logic        w_wash_end;

  // Widened compare so a FULL_LEVEL above the sensor range can never be reached
  assign w_full     = ({22'd0, water_level_sensor} >= FULL_LEVEL);
  assign w_empty    = ({22'd0, water_level_sensor} <= EMPTY_LEVEL);
  assign w_wash_end = (r_wash_cnt == WASH_LAST);

`ifdef WFC_RETRY_EN
  logic       r_retry;
  logic       w_next_retry;
  logic [2:0] r_resume;
  logic [2:0] w_next_resume;
`endif

  // Next-state, wash counter and retry bookkeeping
  always_comb begin
    w_next_state    = r_state;
    w_next_wash_cnt = r_wash_cnt;
`ifdef WFC_RETRY_EN
    w_next_retry    = r_retry;
    w_next_resume   = r_resume;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_FILL;
`ifdef WFC_RETRY_EN
          w_next_retry = 1'b0;
`endif
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_full) begin
          w_next_state    = ST_WASH;
          w_next_wash_cnt = 16'd0;
        end else if (error_flag) begin
`ifdef WFC_RETRY_EN
          if (r_retry) begin
            w_next_state = ST_FAULT;
          end else begin
            w_next_state  = ST_RECOVER;
            w_next_retry  = 1'b1;
            w_next_resume = ST_FILL;
          end
`else
          w_next_state = ST_FAULT;
`endif
        end else if (abort) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_WASH: begin
        if (abort || w_wash_end) begin
          w_next_state    = ST_DRAIN;
          w_next_wash_cnt = 16'd0;
        end else begin
          w_next_wash_cnt = r_wash_cnt + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_next_state = ST_DONE;
        end else if (error_flag) begin
`ifdef WFC_RETRY_EN
          if (r_retry) begin
            w_next_state = ST_FAULT;
          end else begin
            w_next_state  = ST_RECOVER;
            w_next_retry  = 1'b1;
            w_next_resume = ST_DRAIN;
          end
`else
          w_next_state = ST_FAULT;
`endif
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      ST_FAULT: begin
        if (clear_fault) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FAULT;
        end
      end
`ifdef WFC_RETRY_EN
      ST_RECOVER: w_next_state = r_resume;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, counter and output registers; outputs are decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wash_cnt <= 16'd0;
      r_outputs  <= decode_outputs(ST_IDLE);
    end else begin
      r_state    <= w_next_state;
      r_wash_cnt <= w_next_wash_cnt;
      r_outputs  <= decode_outputs(w_next_state);
    end
  end

`ifdef WFC_RETRY_EN
  // Retry flag and resume phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retry  <= 1'b0;
      r_resume <= ST_FILL;
    end else begin
      r_retry  <= w_next_retry;
      r_resume <= w_next_resume;
    end
  end
`endif

  assign state       = r_state;
  assign mode        = r_outputs[5];
  assign mon_reset   = r_outputs[4];
  assign inlet_valve = r_outputs[3];
  assign drain_valve = r_outputs[2];
  assign done        = r_outputs[1];
  assign fault       = r_outputs[0];

endmodule

// File: tb/tb_water_cycle_controller.sv
// Scoreboard bench for water_cycle_controller: a phase-level reference model queues the
// expected outputs for every cycle, and an independent monitor compares after each edge.
module tb_water_cycle_controller;

  localparam int FULL  = 800;
  localparam int EMPTY = 20;
  localparam int WASH  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       clear_fault = 1'b0;
  logic [9:0] water_level_sensor = 10'd0;
  logic       error_flag = 1'b0;
  logic       mode, mon_reset, inlet_valve, drain_valve, done, fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  water_cycle_controller #(
    .FULL_LEVEL (FULL),
    .EMPTY_LEVEL(EMPTY),
    .WASH_CYCLES(WASH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .clear_fault       (clear_fault),
    .water_level_sensor(water_level_sensor),
    .error_flag        (error_flag),
    .mode              (mode),
    .mon_reset         (mon_reset),
    .inlet_valve       (inlet_valve),
    .drain_valve       (drain_valve),
    .done              (done),
    .fault             (fault),
    .state             (state)
  );

  // Expected observable outputs: state, mode, mon_reset, inlet, drain, done, fault
  typedef logic [8:0] exp_t;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Phase-level reference model
  int m_phase   = 0;   // 0 idle,1 fill,2 wash,3 drain,4 done,5 fault,6 recover
  int m_washed  = 0;   // wash cycles already spent
  int m_resume  = 1;
  bit m_retried = 1'b0;
  int tank      = 0;

  function automatic exp_t expected_for(input int ph);
    bit filling, draining;
    filling  = (ph == 1);
    draining = (ph == 3);
    return {3'(ph), filling, !(filling || draining), filling, draining, (ph == 4), (ph == 5)};
  endfunction

  task automatic flow_error(input int phase_now);
`ifdef WFC_RETRY_EN
    if (m_retried) m_phase = 5;
    else begin
      m_phase   = 6;
      m_retried = 1'b1;
      m_resume  = phase_now;
    end
`else
    m_phase = 5;
    if (phase_now < 0) m_phase = 0;
`endif
  endtask

  task automatic model(input bit r, st, ab, clr, err, input int lvl);
    if (r) begin
      m_phase = 0; m_washed = 0; m_retried = 1'b0;
    end else begin
      case (m_phase)
        0: if (st) begin m_phase = 1; m_retried = 1'b0; end
        1: if (lvl >= FULL) begin m_phase = 2; m_washed = 0; end
           else if (err) flow_error(1);
           else if (ab) m_phase = 3;
        2: begin
             m_washed++;
             if (ab || m_washed == WASH) m_phase = 3;
           end
        3: if (lvl <= EMPTY) m_phase = 4;
           else if (err) flow_error(3);
        4: m_phase = 0;
        5: if (clr) m_phase = 0;
        6: m_phase = m_resume;
        default: m_phase = 0;
      endcase
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next edge
  task automatic step(input bit r, st, ab, clr, err, input int lvl);
    @(negedge clk);
    reset = r; start = st; abort = ab; clear_fault = clr; error_flag = err;
    water_level_sensor = 10'(lvl);
    model(r, st, ab, clr, err, lvl);
    exp_q.push_back(expected_for(m_phase));
  endtask

  task automatic move_tank(input int delta);
    if (m_phase == 1) tank = tank + delta;
    else if (m_phase == 3) tank = tank - delta;
    if (tank < 0) tank = 0;
    if (tank > 1023) tank = 1023;
  endtask

  task automatic run_until_idle(input string name, input int delta);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tank);
      move_tank(delta);
      if (m_phase == 0) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL %s timeout: model phase=%0d, required return to idle", name, m_phase);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare after the edge
  exp_t mon_exp;
  exp_t mon_act;
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {state, mode, mon_reset, inlet_valve, drain_valve, done, fault};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL outputs cycle=%0d actual st=%0d m/mr/in/dr/dn/ft=%b required st=%0d m/mr/in/dr/dn/ft=%b",
                 cycle, mon_act[8:6], mon_act[5:0], mon_exp[8:6], mon_exp[5:0]);
      end
      checks++;
      if (inlet_valve && drain_valve) begin
        failures++;
        $display("FAIL valve_exclusive cycle=%0d actual both open required at most one", cycle);
      end
    end
  end

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 900);

    // Normal run: +20 per cycle to 800, wash, -20 per cycle to 20
    tank = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tank);
    move_tank(20);
    run_until_idle("normal_run", 20);

    // Fill error at 300, start ignored in fault, then clear
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 300);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 300);

    // Level boundary beats error, wash aborted, drain boundary 21 vs 20
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 799);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 800);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 800);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 21);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20);

    // Abort in fill at 400, then reset mid-drain at 500
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 400);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 500);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 500);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 500);

    // Two errors in one run, then a drain error in a fresh run
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 300);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 300);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized traffic with a tank that follows the expected valves
    tank = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, st, ab, clr, err;
      r   = ($urandom_range(0, 249) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 4) == 0);
      err = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) tank = int'($urandom_range(0, 1023));
      step(r, st, ab, clr, err, tank);
      move_tank(int'($urandom_range(0, 60)));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
